sliding_window_unit: RTL and testbench

//  Receiving end of the fetch_unit pixel stream: accepts image pixels in row-major order on
//  fu_pixel_in/fu_pixel_valid_in, keeps the last K-1 image rows in line buffers, and emits every

---
 rtl/sliding_window_unit.sv | 163 ++++++++++++++++
 tb/tb_sliding_window_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_unit.sv
// Sliding KxK window generator over a row-major NxN pixel stream.
// Ports: clk/rstn, fu_* config+pixel in, fu_window_* out, frame_done_out, cfg_err_out.
module sliding_window_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_KERNEL_SIZE   = 5,
  parameter int KERNEL_SIZE_WIDTH = 3,
  parameter int IMG_SIZE_WIDTH    = 12,
  parameter int MAX_IMG_WIDTH     = 64
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [KERNEL_SIZE_WIDTH-1:0] fu_kernel_size_in,
  input  logic [IMG_SIZE_WIDTH-1:0]    fu_img_size_in,
  input  logic [DATA_WIDTH-1:0]        fu_pixel_in,
  input  logic                         fu_pixel_valid_in,
  output logic [MAX_KERNEL_SIZE*MAX_KERNEL_SIZE*DATA_WIDTH-1:0]
                                       fu_window_out,
  output logic                         fu_window_valid_out,
  output logic                         frame_done_out,
  output logic                         cfg_err_out
);
  localparam int MK = MAX_KERNEL_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int NE = MK * MK;
  localparam int AW = $clog2(MAX_IMG_WIDTH);
  localparam int EW = $clog2(NE);

  typedef enum logic [1:0] {IDLE, RUN, DISCARD} state_t;

  state_t                       state;
  logic [KERNEL_SIZE_WIDTH-1:0] k_q;
  logic [IMG_SIZE_WIDTH-1:0]    n_q;
  logic [IMG_SIZE_WIDTH-1:0]    row;
  logic [IMG_SIZE_WIDTH-1:0]    col;
  logic [DW-1:0]                win  [MK][MK];
  logic [DW-1:0]                nwin [MK][MK];
  logic [DW-1:0]                lb   [MK-1][MAX_IMG_WIDTH];
  logic [DW-1:0]                lb_col [MK-1];
  logic [DW-1:0]                elem [NE];
  logic [NE*DW-1:0]             pack;

  logic [KERNEL_SIZE_WIDTH-1:0] k_eff;
  logic [IMG_SIZE_WIDTH-1:0]    n_eff;
  logic [AW-1:0]                col_a;
  logic                         legal;
  logic                         run_path;
  logic                         last;
  logic                         col_end;
  logic                         emit;
  int                           kc;
  int                           off;
  int                           ei;
  int                           ej;
  logic [EW-1:0]                eidx;

  // The first pixel of a frame uses the live config inputs.
  always_comb begin
    k_eff = (state == IDLE) ? fu_kernel_size_in : k_q;
    n_eff = (state == IDLE) ? fu_img_size_in : n_q;
    legal = (int'(k_eff) >= 1) && (int'(k_eff) <= MK) &&
            (int'(k_eff) <= int'(n_eff)) &&
            (int'(n_eff) <= MAX_IMG_WIDTH);
    run_path = fu_pixel_valid_in &&
               ((state == RUN) || ((state == IDLE) && legal));
    col_end = (col == n_eff - IMG_SIZE_WIDTH'(1));
    last    = col_end && (row == n_eff - IMG_SIZE_WIDTH'(1));
    emit    = run_path &&
              (int'(row) >= int'(k_eff) - 1) &&
              (int'(col) >= int'(k_eff) - 1);
    col_a   = col[AW-1:0];
  end

  // Next window: shift left, new column = older rows from line buffers.
  always_comb begin
    for (int j = 0; j < MK - 1; j++)
      lb_col[j] = lb[j][col_a];
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK - 1; j++)
        nwin[i][j] = win[i][j+1];
    for (int i = 0; i < MK - 1; i++)
      nwin[i][MK-1] = lb_col[MK-2-i];
    nwin[MK-1][MK-1] = fu_pixel_in;
  end

  // The active KxK lives in the bottom-right corner of the array.
  always_comb begin
    kc  = legal ? int'(k_eff) : 1;
    off = MK - kc;
    ei  = 0;
    ej  = 0;
    eidx = '0;
    for (int e = 0; e < NE; e++)
      elem[e] = '0;
    for (int pi = 0; pi < MK; pi++)
      for (int pj = 0; pj < MK; pj++) begin
        ei = pi - off;
        ej = pj - off;
        if (ei >= 0 && ej >= 0) begin
          eidx = EW'(ei * kc + ej);
          elem[eidx] = nwin[pi][pj];
        end
      end
    for (int e = 0; e < NE; e++)
      pack[e*DW +: DW] = elem[e];
  end

  always_ff @(posedge clk) begin
    if (run_path) begin
      lb[0][col_a] <= fu_pixel_in;
      for (int j = 1; j < MK - 1; j++)
        lb[j][col_a] <= lb[j-1][col_a];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state               <= IDLE;
      k_q                 <= '0;
      n_q                 <= '0;
      row                 <= '0;
      col                 <= '0;
      fu_window_out       <= '0;
      fu_window_valid_out <= 1'b0;
      frame_done_out      <= 1'b0;
      cfg_err_out         <= 1'b0;
      for (int i = 0; i < MK; i++)
        for (int j = 0; j < MK; j++)
          win[i][j] <= '0;
    end else begin
      fu_window_valid_out <= 1'b0;
      frame_done_out      <= 1'b0;
      cfg_err_out         <= 1'b0;
      if (fu_pixel_valid_in) begin
        if (state == IDLE) begin
          k_q         <= fu_kernel_size_in;
          n_q         <= fu_img_size_in;
          cfg_err_out <= !legal;
        end
        if (last) begin
          row            <= '0;
          col            <= '0;
          state          <= IDLE;
          frame_done_out <= 1'b1;
        end else begin
          if (state == IDLE)
            state <= legal ? RUN : DISCARD;
          if (col_end) begin
            col <= '0;
            row <= row + IMG_SIZE_WIDTH'(1);
          end else begin
            col <= col + IMG_SIZE_WIDTH'(1);
          end
        end
        if (run_path)
          win <= nwin;
        if (emit) begin
          fu_window_valid_out <= 1'b1;
          fu_window_out       <= pack;
        end
      end
    end
  end
endmodule

// File: tb/tb_sliding_window_unit.sv
// Scoreboard bench for sliding_window_unit.
// Driver pushes expected windows; a negedge monitor pops and compares.
module tb_sliding_window_unit;
  localparam int DW = 32;
  localparam int MK = 5;
  localparam int WW = MK * MK * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [2:0]    ksz = '0;
  logic [11:0]   isz = '0;
  logic [DW-1:0] pix = '0;
  logic          valid = 1'b0;
  logic [WW-1:0] win_out;
  logic          win_valid;
  logic          done;
  logic          err;

  sliding_window_unit dut (
    .clk                 (clk),
    .rstn                (rstn),
    .fu_kernel_size_in   (ksz),
    .fu_img_size_in      (isz),
    .fu_pixel_in         (pix),
    .fu_pixel_valid_in   (valid),
    .fu_window_out       (win_out),
    .fu_window_valid_out (win_valid),
    .frame_done_out      (done),
    .cfg_err_out         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] w;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   obs_done = 0;
  int   obs_err = 0;
  int   exp_done = 0;
  int   exp_err = 0;

  always @(posedge clk) cyc++;

  function automatic logic [WW-1:0] expwin(
    input int base, input int n, input int k,
    input int r, input int c);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        w[(i*k+j)*DW +: DW] =
          32'(base + (r-k+1+i)*n + (c-k+1+j));
    return w;
  endfunction

  task automatic check(input string name,
                       input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (win_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL window_unexpected at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          if (win_out !== e.w) begin
            errors++;
            for (int k = 0; k < MK*MK; k++)
              if (win_out[k*DW +: DW] !== e.w[k*DW +: DW]) begin
                $display("FAIL window_data elem %0d actual %0d required %0d",
                         k, win_out[k*DW +: DW], e.w[k*DW +: DW]);
                break;
              end
          end
          checks++;
          if (done !== e.last) begin
            errors++;
            $display("FAIL done_with_window actual %0b required %0b",
                     done, e.last);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL window_latency actual %0d required %0d",
                     cyc, e.cyc);
          end
        end
      end
      if (done) obs_done++;
      if (err) obs_err++;
    end
  end

  task automatic send_frame(input int k, input int n,
                            input int base, input int gmax,
                            input int npix);
    bit legal;
    int r;
    int c;
    int g;
    exp_t x;
    legal = k >= 1 && k <= MK && k <= n && n <= 64;
    if (!legal) exp_err++;
    if (npix == n*n) exp_done++;
    for (int p = 0; p < npix; p++) begin
      r = p / n;
      c = p % n;
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      repeat (g) begin
        @(negedge clk);
        valid = 1'b0;
        pix = $urandom;
      end
      @(negedge clk);
      valid = 1'b1;
      pix = 32'(base + p);
      if (p == 0) begin
        ksz = 3'(k);
        isz = 12'(n);
      end else begin
        ksz = 3'($urandom);
        isz = 12'($urandom);
      end
      if (legal && r >= k-1 && c >= k-1) begin
        x.w = expwin(base, n, k, r, c);
        x.last = (p == n*n - 1);
        x.cyc = cyc + 1;
        q.push_back(x);
      end
    end
  endtask

  task automatic end_case(input string name);
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check({name, "_pending"}, q.size(), 0);
    check({name, "_done"}, obs_done, exp_done);
    check({name, "_cfgerr"}, obs_err, exp_err);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", int'(win_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_window_zero", int'(win_out == '0), 1);
    rstn = 1'b1;
    @(negedge clk);

    send_frame(3, 4, 100, 0, 16);
    end_case("k3n4");
    send_frame(3, 4, 100, 3, 16);
    end_case("k3n4_gaps");
    send_frame(1, 4, 100, 0, 16);
    end_case("k1n4");
    send_frame(5, 5, 0, 0, 25);
    end_case("k5n5");
    send_frame(0, 4, 7, 0, 16);
    end_case("k0");
    send_frame(6, 6, 7, 1, 36);
    end_case("k6");
    send_frame(3, 2, 7, 0, 4);
    end_case("k3n2");

    send_frame(3, 4, 100, 0, 7);
    @(negedge clk);
    valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_valid", int'(win_valid), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_window_zero", int'(win_out == '0), 1);
    rstn = 1'b1;
    @(negedge clk);
    send_frame(3, 4, 100, 0, 16);
    end_case("after_rst");

    send_frame(3, 4, 100, 0, 16);
    send_frame(2, 3, 0, 0, 9);
    end_case("back2back");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
